// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending credit controller.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam int N_INLET_DEF  = 2;
    localparam int COIN_W_DEF   = 4;
    localparam int CREDIT_W_DEF = 6;
    localparam int PRICE_DEF    = 15;
    localparam int CHG_UNIT_DEF = 5;
    localparam int TIMEOUT_DEF  = 255;

    typedef logic [CREDIT_W_DEF-1:0] credit_t;

endpackage

// File: rtl/vend_credit_controller_if.sv
// Coin inlets, dispenser handshake, change ejector and status bundle.
interface vend_credit_controller_if #(
    parameter int N_INLET  = vend_pkg::N_INLET_DEF,
    parameter int COIN_W   = vend_pkg::COIN_W_DEF,
    parameter int CREDIT_W = vend_pkg::CREDIT_W_DEF
);
    logic [N_INLET-1:0]        coin_req;
    logic [N_INLET*COIN_W-1:0] coin_val;
    logic [N_INLET-1:0]        coin_ack;
    logic                      cancel;
    logic                      vend_valid;
    logic                      vend_ready;
    logic                      chg_pulse;
    logic [CREDIT_W-1:0]       credit;
    logic                      busy;

    modport master (
        output coin_req, coin_val, cancel, vend_ready,
        input  coin_ack, vend_valid, chg_pulse, credit, busy
    );

    modport slave (
        input  coin_req, coin_val, cancel, vend_ready,
        output coin_ack, vend_valid, chg_pulse, credit, busy
    );
endinterface

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin picker: first unmasked request at or after ptr.
module vend_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);
    logic [N-1:0] elig;
    logic         found;
    int           idx;

    always_comb begin
        elig    = req_i & ~mask_i;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && elig[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vend_credit_controller.sv
// Vending sequencer: round-robin coin intake, vend handshake,
// paced change return and idle auto-refund.
module vend_credit_controller
    import vend_pkg::*;
#(
    parameter int N_INLET  = N_INLET_DEF,
    parameter int COIN_W   = COIN_W_DEF,
    parameter int CREDIT_W = CREDIT_W_DEF,
    parameter int PRICE    = PRICE_DEF,
    parameter int CHG_UNIT = CHG_UNIT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    vend_credit_controller_if.slave io
);
    localparam int PW = (N_INLET > 1) ? $clog2(N_INLET) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CHG_C   = CREDIT_W'(CHG_UNIT);
    localparam logic [TW-1:0]       TMO_END = TW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [N_INLET-1:0]  ack_q, ack_d;
    logic                vv_q, vv_d;
    logic                chg_q, chg_d;
    logic                busy_q, busy_d;
    logic [PW-1:0]       ptr_q, ptr_d, nxt_ptr;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [N_INLET-1:0]  req_en, grant;
    logic [COIN_W-1:0]   sel_val;
    logic [CREDIT_W:0]   sum;
    logic                credit_nz;

    assign req_en    = (state_q == COLLECT) ? io.coin_req : '0;
    assign credit_nz = |credit_q;

    // an inlet acked this cycle is masked so its held request is not recounted
    vend_rr_arbiter #(
        .N  (N_INLET),
        .PW (PW)
    ) u_arb (
        .req_i   (req_en),
        .mask_i  (ack_q),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        sel_val = '0;
        nxt_ptr = ptr_q;
        for (int k = 0; k < N_INLET; k++) begin
            if (grant[k]) begin
                sel_val = io.coin_val[k*COIN_W +: COIN_W];
                nxt_ptr = PW'((k + 1) % N_INLET);
            end
        end
    end

    assign sum = {1'b0, credit_q} + (CREDIT_W+1)'(sel_val);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        ack_d    = '0;
        vv_d     = vv_q;
        chg_d    = 1'b0;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            COLLECT: begin
                if (io.cancel && credit_nz) begin
                    state_d = CHANGE;
                    tmo_d   = '0;
                end else if (|grant) begin
                    ack_d    = grant;
                    credit_d = sum[CREDIT_W-1:0];
                    ptr_d    = nxt_ptr;
                    tmo_d    = '0;
                    if (sum >= {1'b0, PRICE_C}) begin
                        state_d = VEND;
                        vv_d    = 1'b1;
                    end
                end else if (!credit_nz) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_END) begin
                    state_d = CHANGE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            VEND: begin
                if (vv_q && io.vend_ready) begin
                    vv_d     = 1'b0;
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q != PRICE_C) ? CHANGE : COLLECT;
                end
            end
            CHANGE: begin
                // a pulse cycle is always followed by one idle cycle
                if (chg_q) begin
                    chg_d = 1'b0;
                end else if (credit_q >= CHG_C) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - CHG_C;
                end else begin
                    credit_d = '0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            ack_q    <= '0;
            vv_q     <= 1'b0;
            chg_q    <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            ack_q    <= ack_d;
            vv_q     <= vv_d;
            chg_q    <= chg_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign io.coin_ack   = ack_q;
    assign io.vend_valid = vv_q;
    assign io.chg_pulse  = chg_q;
    assign io.credit     = credit_q;
    assign io.busy       = busy_q;

    a_no_wrap: assert property (
        @(posedge clk) disable iff (!rst_n) !sum[CREDIT_W]
    );
endmodule

// File: tb/tb_vend_credit_controller.sv
// Directed bench for vend_credit_controller: vector table plus
// hand-written cancel, stall, timeout and reset sequences.
module tb_vend_credit_controller;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    vend_credit_controller_if #(
        .N_INLET  (2),
        .COIN_W   (4),
        .CREDIT_W (6)
    ) bus ();

    vend_credit_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        bit         rst;
        logic [1:0] req;
        logic [7:0] val;
        bit         cancel;
        bit         ready;
        logic [1:0] ack;
        bit         vv;
        bit         chg;
        credit_t    cr;
        bit         busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, logic [1:0] rq, logic [7:0] v,
                                bit c, bit rd, logic [1:0] a, bit vv,
                                bit ch, int cr, bit b);
        vec_t x;
        x.rst = r; x.req = rq; x.val = v; x.cancel = c; x.ready = rd;
        x.ack = a; x.vv = vv; x.chg = ch; x.cr = credit_t'(cr); x.busy = b;
        return x;
    endfunction

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.coin_req = '0;
        bus.coin_val = '0;
        bus.cancel = 1'b0;
        bus.vend_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_out(string nm, vec_t v);
        chk({nm, "_ack"}, int'(bus.coin_ack), int'(v.ack));
        chk({nm, "_vv"}, int'(bus.vend_valid), int'(v.vv));
        chk({nm, "_chg"}, int'(bus.chg_pulse), int'(v.chg));
        chk({nm, "_credit"}, int'(bus.credit), int'(v.cr));
        chk({nm, "_busy"}, int'(bus.busy), int'(v.busy));
    endtask

    int np, p1, p2, ackc, cr5, b5, k, n, nv, nb, na;

    initial begin
        bus.coin_req = '0;
        bus.coin_val = '0;
        bus.cancel = 1'b0;
        bus.vend_ready = 1'b0;

        // single inlet, 5+5+5, ready tied high; second row checks masking
        vt.push_back(mk(1, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0,  0, 0));
        vt.push_back(mk(0, 2'b01, 8'h05, 0, 1, 2'b01, 0, 0,  5, 0));
        vt.push_back(mk(0, 2'b01, 8'h05, 0, 1, 2'b00, 0, 0,  5, 0));
        vt.push_back(mk(0, 2'b01, 8'h05, 0, 1, 2'b01, 0, 0, 10, 0));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0, 10, 0));
        vt.push_back(mk(0, 2'b01, 8'h05, 0, 1, 2'b01, 1, 0, 15, 1));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0,  0, 0));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0,  0, 0));
        // two inlets: order 0,1,0 reaching 20, vend, one change pulse
        vt.push_back(mk(1, 2'b00, 8'h00, 0, 0, 2'b00, 0, 0,  0, 0));
        vt.push_back(mk(0, 2'b11, 8'h55, 0, 1, 2'b01, 0, 0,  5, 0));
        vt.push_back(mk(0, 2'b11, 8'h55, 0, 1, 2'b10, 0, 0, 10, 0));
        vt.push_back(mk(0, 2'b11, 8'h5A, 0, 1, 2'b01, 1, 0, 20, 1));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0,  5, 1));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 1,  0, 1));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0,  0, 1));
        vt.push_back(mk(0, 2'b00, 8'h00, 0, 1, 2'b00, 0, 0,  0, 0));

        foreach (vt[i]) begin
            if (vt[i].rst) begin
                do_reset();
            end else begin
                bus.coin_req = vt[i].req;
                bus.coin_val = vt[i].val;
                bus.cancel = vt[i].cancel;
                bus.vend_ready = vt[i].ready;
                step();
            end
            chk_out($sformatf("v%0d", i), vt[i]);
        end

        // cancel beats a coincident coin; two spaced pulses; coin acked after
        do_reset();
        bus.coin_val = 8'h0A;
        bus.coin_req = 2'b01;
        step();
        bus.coin_req = 2'b00;
        step();
        chk("t3_credit10", int'(bus.credit), 10);
        bus.coin_val = 8'h5A;
        bus.coin_req = 2'b10;
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("t3_no_ack", int'(bus.coin_ack), 0);
        chk("t3_busy", int'(bus.busy), 1);
        np = 0; p1 = -1; p2 = -1; ackc = -1; cr5 = -1; b5 = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus.chg_pulse) begin
                np++;
                if (p1 < 0) p1 = i;
                else if (p2 < 0) p2 = i;
            end
            if (bus.coin_ack[1] && ackc < 0) begin
                ackc = i;
                bus.coin_req = 2'b00;
            end
            if (i == 5) begin
                cr5 = int'(bus.credit);
                b5 = int'(bus.busy);
            end
        end
        chk("t3_pulses", np, 2);
        chk("t3_spacing", p2 - p1, 2);
        chk("t3_credit_idle", cr5, 0);
        chk("t3_busy_idle", b5, 0);
        chk("t3_ack_cycle", ackc, 6);
        chk("t3_credit_end", int'(bus.credit), 5);

        // dispenser stalls for 20 cycles with a coin pending
        do_reset();
        bus.coin_val = 8'h0F;
        bus.coin_req = 2'b01;
        step();
        bus.coin_req = 2'b00;
        chk("t4_vv", int'(bus.vend_valid), 1);
        bus.coin_val = 8'h5F;
        bus.coin_req = 2'b10;
        nv = 0; nb = 0; na = 0;
        repeat (20) begin
            step();
            nv += int'(bus.vend_valid);
            nb += int'(bus.busy);
            na += int'(|bus.coin_ack);
        end
        chk("t4_vv_cycles", nv, 20);
        chk("t4_busy_cycles", nb, 20);
        chk("t4_ack_cycles", na, 0);
        chk("t4_credit_stall", int'(bus.credit), 15);
        bus.vend_ready = 1'b1;
        step();
        chk("t4_credit_vend", int'(bus.credit), 0);
        chk("t4_vv_drop", int'(bus.vend_valid), 0);
        chk("t4_busy_drop", int'(bus.busy), 0);
        step();
        chk("t4_pending_ack", int'(bus.coin_ack), 2);
        chk("t4_pending_credit", int'(bus.credit), 5);
        bus.coin_req = 2'b00;

        // idle credit auto-refund
        do_reset();
        bus.coin_val = 8'h05;
        bus.coin_req = 2'b01;
        step();
        bus.coin_req = 2'b00;
        chk("t5_credit5", int'(bus.credit), 5);
        k = 0;
        while (!bus.busy && k < 400) begin
            step();
            k++;
        end
        chk("t5_timeout_cycles", k, 255);
        np = 0; n = 0;
        while (bus.busy && n < 20) begin
            step();
            n++;
            np += int'(bus.chg_pulse);
        end
        chk("t5_pulses", np, 1);
        chk("t5_credit", int'(bus.credit), 0);
        chk("t5_busy_end", int'(bus.busy), 0);

        // asynchronous reset in the middle of a change train
        do_reset();
        bus.coin_val = 8'h0A;
        bus.coin_req = 2'b01;
        step();
        bus.coin_req = 2'b00;
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        n = 0;
        while (!bus.chg_pulse && n < 10) begin
            step();
            n++;
        end
        chk("t6_in_pulse", int'(bus.chg_pulse), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", int'(bus.coin_ack), 0);
        chk("t6_rst_vv", int'(bus.vend_valid), 0);
        chk("t6_rst_chg", int'(bus.chg_pulse), 0);
        chk("t6_rst_credit", int'(bus.credit), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_post_busy", int'(bus.busy), 0);
        chk("t6_post_chg", int'(bus.chg_pulse), 0);
        bus.coin_val = 8'h05;
        bus.coin_req = 2'b01;
        step();
        bus.coin_req = 2'b00;
        chk("t6_post_ack", int'(bus.coin_ack), 1);
        chk("t6_post_credit", int'(bus.credit), 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
